count_seq_ctrl: RTL and testbench

COUNT_SEQ_CTRL -- requirements
Module: count_seq_ctrl

---
 rtl/count_seq_ctrl.sv | 111 +++++++++++
 tb/tb_count_seq_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/count_seq_ctrl.sv
// Two-phase sequencer: counter Q1 runs 0..A_MAX, then counter Q2 runs 0..B_MAX,
// then a single DONE cycle. Supports hold (freeze) and abort (back to IDLE).
module count_seq_ctrl #(
  parameter logic [3:0] A_MAX = 4'd9,
  parameter logic [2:0] B_MAX = 3'd7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hold,
  input  logic       abort,
  output logic [3:0] Q1,
  output logic [2:0] Q2,
  output logic [1:0] state,
  output logic       busy,
  output logic       done
);

  localparam int unsigned A_W = 4;
  localparam int unsigned B_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN_A = 2'b01,
    RUN_B = 2'b10,
    DONE  = 2'b11
  } state_e;

  state_e         state_q, state_d;
  logic [A_W-1:0] q1_q, q1_d;
  logic [B_W-1:0] q2_q, q2_d;
  logic           busy_q, done_q;

  // Next-state and counter update; abort beats hold beats count.
  always_comb begin
    state_d = state_q;
    q1_d    = q1_q;
    q2_d    = q2_q;
    case (state_q)
      IDLE: begin
        q1_d = '0;
        q2_d = '0;
        if (start) state_d = RUN_A;
      end
      RUN_A: begin
        if (abort) begin
          state_d = IDLE;
          q1_d    = '0;
          q2_d    = '0;
        end else if (!hold) begin
          if (q1_q >= A_MAX) begin
            state_d = RUN_B;
            q1_d    = '0;
            q2_d    = '0;
          end else begin
            q1_d = A_W'(q1_q + 1'b1);
          end
        end
      end
      RUN_B: begin
        if (abort) begin
          state_d = IDLE;
          q1_d    = '0;
          q2_d    = '0;
        end else if (!hold) begin
          q1_d = '0;
          if (q2_q >= B_MAX) begin
            state_d = DONE;
            q2_d    = '0;
          end else begin
            q2_d = B_W'(q2_q + 1'b1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        q1_d    = '0;
        q2_d    = '0;
      end
      default: begin
        state_d = IDLE;
        q1_d    = '0;
        q2_d    = '0;
      end
    endcase
  end

  // busy/done are flops loaded from the next state, so they track state exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q1_q    <= '0;
      q2_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q1_q    <= q1_d;
      q2_q    <= q2_d;
      busy_q  <= (state_d == RUN_A) || (state_d == RUN_B);
      done_q  <= (state_d == DONE);
    end
  end

  assign Q1    = q1_q;
  assign Q2    = q2_q;
  assign state = state_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl: vector table for the main sequences plus
// hand-written reset and A_MAX=B_MAX=0 corner cases.
module tb_count_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, hold, abort;
  logic       start0;
  logic       zero0;
  logic [3:0] Q1, Q1z;
  logic [2:0] Q2, Q2z;
  logic [1:0] state, statez;
  logic       busy, done, busyz, donez;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct packed {
    logic       st;
    logic       hd;
    logic       ab;
    logic [3:0] q1;
    logic [2:0] q2;
    logic [1:0] s;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  count_seq_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .abort(abort),
    .Q1(Q1), .Q2(Q2), .state(state), .busy(busy), .done(done)
  );

  count_seq_ctrl #(.A_MAX(4'd0), .B_MAX(3'd0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .hold(zero0), .abort(zero0),
    .Q1(Q1z), .Q2(Q2z), .state(statez), .busy(busyz), .done(donez)
  );

  task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got {Q1,Q2,state,busy,done}=%h expected %h", name, act, exp);
  endtask

  function automatic logic [10:0] expo(input logic [3:0] q1, input logic [2:0] q2,
                                       input logic [1:0] s);
    return {q1, q2, s, (s == 2'b01) || (s == 2'b10), s == 2'b11};
  endfunction

  task automatic add(input logic st, input logic hd, input logic ab,
                     input logic [3:0] q1, input logic [2:0] q2, input logic [1:0] s);
    vec_t v;
    v = '{st: st, hd: hd, ab: ab, q1: q1, q2: q2, s: s};
    vecs.push_back(v);
  endtask

  task automatic cyc(input logic st, input logic hd, input logic ab);
    @(negedge clk);
    start = st;
    hold  = hd;
    abort = ab;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int edges;
    rst = 1'b1; start = 1'b0; hold = 1'b0; abort = 1'b0; start0 = 1'b0; zero0 = 1'b0;

    // Idle behaviour: hold/abort ignored, nothing without start.
    add(0, 0, 0, 0, 0, 2'b00);
    add(0, 1, 1, 0, 0, 2'b00);
    // Plain default sequence.
    add(1, 0, 0, 0, 0, 2'b01);
    for (int i = 1; i <= 9; i++) add(0, 0, 0, 4'(i), 0, 2'b01);
    for (int j = 0; j <= 7; j++) add(0, 0, 0, 0, 3'(j), 2'b10);
    add(0, 0, 0, 0, 0, 2'b11);
    add(0, 0, 0, 0, 0, 2'b00);
    // Hold at Q1=4 for 3 cycles; start ignored in RUN_B and DONE.
    add(1, 0, 0, 0, 0, 2'b01);
    for (int i = 1; i <= 4; i++) add(0, 0, 0, 4'(i), 0, 2'b01);
    for (int i = 0; i < 3; i++) add(0, 1, 0, 4, 0, 2'b01);
    for (int i = 5; i <= 9; i++) add(0, 0, 0, 4'(i), 0, 2'b01);
    for (int j = 0; j <= 7; j++) add((j == 3) ? 1'b1 : 1'b0, 0, 0, 0, 3'(j), 2'b10);
    add(0, 0, 0, 0, 0, 2'b11);
    add(1, 1, 1, 0, 0, 2'b00);
    add(0, 0, 0, 0, 0, 2'b00);
    // start+abort in IDLE enters RUN_A; hold in RUN_B; abort+hold at Q2=3.
    add(1, 0, 1, 0, 0, 2'b01);
    for (int i = 1; i <= 9; i++) add(0, 0, 0, 4'(i), 0, 2'b01);
    for (int j = 0; j <= 3; j++) add(0, 0, 0, 0, 3'(j), 2'b10);
    add(0, 1, 0, 0, 3, 2'b10);
    add(0, 1, 1, 0, 0, 2'b00);
    add(0, 0, 0, 0, 0, 2'b00);
    // Abort during RUN_A.
    add(1, 0, 0, 0, 0, 2'b01);
    add(0, 0, 0, 1, 0, 2'b01);
    add(0, 1, 1, 0, 0, 2'b00);
    // Restart after abort begins cleanly at Q1=0.
    add(1, 0, 0, 0, 0, 2'b01);
    add(0, 0, 1, 0, 0, 2'b00);

    #2;
    chk("reset_main", {Q1, Q2, state, busy, done}, 11'h0);
    chk("reset_zero_par", {Q1z, Q2z, statez, busyz, donez}, 11'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[k]) begin
      cyc(vecs[k].st, vecs[k].hd, vecs[k].ab);
      chk($sformatf("vec%0d", k), {Q1, Q2, state, busy, done},
          expo(vecs[k].q1, vecs[k].q2, vecs[k].s));
    end

    // Async reset mid-cycle at Q1=6, start held through release.
    cyc(1, 0, 0);
    for (int i = 1; i <= 6; i++) cyc(0, 0, 0);
    chk("pre_reset_q1_6", {Q1, Q2, state, busy, done}, expo(6, 0, 2'b01));
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_clear", {Q1, Q2, state, busy, done}, 11'h0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("held_in_reset", {Q1, Q2, state, busy, done}, 11'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("start_through_release", {Q1, Q2, state, busy, done}, expo(0, 0, 2'b01));
    edges = 0;
    while (!done && edges < 40) begin
      cyc(0, 0, 0);
      edges++;
    end
    total_cnt++;
    if (done && edges == 18) pass_cnt++;
    else $display("FAIL seq_after_reset: done after %0d edges (done=%b) expected 18", edges, done);
    cyc(0, 0, 0);
    chk("idle_after_done", {Q1, Q2, state, busy, done}, 11'h0);

    // A_MAX=0, B_MAX=0 instance: one cycle per phase.
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    chk("zero_run_a", {Q1z, Q2z, statez, busyz, donez}, expo(0, 0, 2'b01));
    cyc(0, 0, 0);
    start0 = 1'b0;
    chk("zero_run_b", {Q1z, Q2z, statez, busyz, donez}, expo(0, 0, 2'b10));
    cyc(0, 0, 0);
    chk("zero_done", {Q1z, Q2z, statez, busyz, donez}, expo(0, 0, 2'b11));
    cyc(0, 0, 0);
    chk("zero_idle", {Q1z, Q2z, statez, busyz, donez}, expo(0, 0, 2'b00));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
